mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences a single shared memory port between the instruction-fetch requester and the data-memory requester.
- The data-memory requester is driven by the decoder's dm_rd/dm_wr/dm_op outputs.
- Owns the memory-side control signals and holds them stable for a fixed access latency.
- Returns read data and a one-cycle acknowledge to the granted requester.

Parameters:
- ADDR_W, 32, address width of both requesters and of the memory port.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access cycles per transfer (legal range 1..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; held stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in this cycle.
- if_rdata  out  DATA_W  fetched word; holds its value until the next fetch completes.
- dm_req  in  1  data request (dm_rd | dm_wr); held until dm_ack.
- dm_wr  in  1  1 = store, 0 = load; held with dm_req.
- dm_op  in  3  access size/sign code; passed through unchanged to mem_op.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DATA_W  load result; updated only by loads.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_op  out  3  size code to memory; 3'b000 for fetches (word).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid on the last access cycle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous; takes effect immediately, including mid-access):
  - state=IDLE, cnt=0.
  - All mem_* outputs 0; if_ack=dm_ack=0; if_rdata=dm_rdata=0; busy=0.
  - Any in-flight transfer is dropped with no ack.
  - Optional-feature last-grant flag = IF.
- States: IDLE, ACC, RESP. All outputs are registered.
- IDLE:
  - If dm_req=1, grant DM (data has fixed priority over fetch); else if if_req=1, grant IF; else stay in IDLE.
  - On grant: latch owner, address, we, op and wdata into the mem_* registers; set mem_en=1 and cnt=MEM_LAT-1; next state ACC.
- ACC:
  - mem_* outputs are held constant.
  - cnt>0: decrement cnt.
  - cnt==0 (last access cycle): sample mem_rdata into the owner's rdata register.
    - For a DM store, dm_rdata is unchanged.
    - Clear mem_en/mem_we; next state RESP.
- RESP:
  - The owner's ack is high for exactly this one cycle; next state IDLE.
- Per-transfer timing:
  - Grant-to-ack latency is MEM_LAT+1 cycles after the IDLE sampling edge.
  - One transfer occupies MEM_LAT+2 cycles.
- Back-to-back requests:
  - A requester with another request keeps req high through the ack cycle; it is re-sampled in the following IDLE cycle.
  - A requester with no further request deasserts req on the edge ending its ack cycle.
- Simultaneous requests in IDLE: DM wins; IF waits. Its if_req stays high and it is served on the next IDLE cycle in which dm_req=0.
- Request changes during ACC/RESP (either requester) are ignored; latched values are used.
- if_ack and dm_ack are never high in the same cycle.
- mem_we is never 1 while the owner is IF.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last-grant register is updated on every grant.
  - When both requests are high in IDLE, grant goes to the requester not granted last.
  - Single requests are granted as usual.
  - Guarantees that no requester waits more than one other transfer.
- Undefined:
  - Fixed DM priority as described above; no last-grant register is instantiated.

Test Plan:
- Reset then IF read, MEM_LAT=2, if_addr=0x00000010, memory returns 0x8C220004:
  - mem_en high for 2 cycles with mem_addr=0x10, mem_op=0.
  - if_ack pulses on the 3rd cycle after the grant edge; if_rdata=0x8C220004; busy falls after the ack.
- DM store, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_op=3'b010:
  - mem_we=1, mem_wdata=0xDEADBEEF for 2 cycles.
  - dm_ack one pulse; dm_rdata keeps its prior value 0.
- IF and DM raised in the same cycle (DM load at 0x200 returning 0x12345678):
  - DM is served first, dm_rdata=0x12345678.
  - IF is served immediately after; acks are 4 cycles apart and never overlap.
- if_req held continuously for 3 fetches:
  - 3 if_ack pulses spaced 4 cycles apart.
  - dm_req asserted mid-stream is granted at the next IDLE.
- rst pulsed during ACC of a DM load:
  - All outputs are 0 immediately, with no dm_ack.
  - After release, a fresh IF request completes normally.
- With MEM_ARB_RR_EN, both requests held high for 4 transfers:
  - Grants alternate DM, IF, DM, IF.
  - Without the macro: DM, DM, DM, DM.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Sequences one shared memory port between the instruction-fetch (IF)
//   requester and the data-memory (DM) requester. A granted transfer drives
//   the mem_* controls for MEM_LAT cycles. The owner's read data is captured
//   on the last access cycle. A one-cycle ack then goes to the owner.
//
//   Ports
//     clk, rst              rising-edge clock, asynchronous active-high reset
//     if_req/if_addr        fetch request; held until if_ack
//     if_ack/if_rdata       one-cycle completion pulse, fetched word
//     dm_req/dm_wr/dm_op    data request, store flag, size/sign code
//     dm_addr/dm_wdata      data address and store data
//     dm_ack/dm_rdata       one-cycle completion pulse, load result
//     mem_en/mem_we/mem_op  memory-side controls (registered)
//     mem_addr/mem_wdata    memory address and write data (registered)
//     mem_rdata             memory read data, valid on the last access cycle
//     busy                  high whenever the arbiter is not idle
//
//   Build option
//     MEM_ARB_RR_EN  When defined, simultaneous requests alternate between the
//                    two requesters, using a last-grant flag. When undefined,
//                    DM has fixed priority over IF.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [2:0]        dm_op,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_DM   = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        mem_op_q, mem_op_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;
  logic              grant_dm_s;
`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  // Grant selection: DM wins a tie unless alternation is enabled.
  always_comb begin
    grant_dm_s = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (dm_req && if_req) begin
      grant_dm_s = (last_q == OWN_IF);
    end else begin
      grant_dm_s = dm_req;
    end
`else
    grant_dm_s = dm_req;
`endif
  end

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (dm_req || if_req) begin
          state_d  = ST_ACC;
          cnt_d    = CNT_INIT;
          mem_en_d = 1'b1;
          owner_d  = grant_dm_s ? OWN_DM : OWN_IF;
`ifdef MEM_ARB_RR_EN
          last_d   = grant_dm_s ? OWN_DM : OWN_IF;
`endif
          if (grant_dm_s) begin
            mem_we_d    = dm_wr;
            mem_op_d    = dm_op;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            // Fetches are always word reads; write data is parked at zero.
            mem_we_d    = 1'b0;
            mem_op_d    = 3'b000;
            mem_addr_d  = if_addr;
            mem_wdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Last access cycle: mem_rdata is valid now.
          if (owner_q == OWN_DM) begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
            dm_ack_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_op_q    <= 3'b000;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      dm_rdata_q  <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. Expected acks are pushed to a queue
//   when requests are raised, then popped and compared as acks appear. The
//   memory model returns valid data only on the last access cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  typedef struct packed {
    logic              is_dm;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_wr;
  logic [2:0]        dm_op;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [2:0]        mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int   n_total = 0;
  int   n_pass  = 0;
  int   en_cnt  = 0;
  exp_t exp_q[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_op(dm_op), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    case (a)
      32'h0000_0010: return 32'h8C22_0004;
      32'h0000_0200: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  function automatic exp_t mk(input logic is_dm, input logic [DATA_W-1:0] rd);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = rd;
    return e;
  endfunction

  // Counts consecutive enabled cycles so data is only valid on the last one.
  always @(posedge clk) begin
    en_cnt <= mem_en ? en_cnt + 1 : 0;
  end

  always_comb begin
    mem_rdata = 32'hBAD0_BAD0;
    if (mem_en && en_cnt == MEM_LAT - 1) mem_rdata = mem_word(mem_addr);
  end

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_wr = 1'b0;
    dm_op = 3'b000; dm_addr = 32'h0; dm_wdata = 32'h0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({mem_en, mem_we, mem_op, mem_addr, mem_wdata, if_ack, dm_ack,
         if_rdata, dm_rdata, busy} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {mem_en, mem_we, mem_op, mem_addr, mem_wdata, if_ack, dm_ack,
                if_rdata, dm_rdata, busy});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b mem_en=%b want 0 0", busy, mem_en);
    else n_pass++;
  endtask

  task automatic test_if_read();
    exp_t ent;
    exp_q.push_back(mk(1'b0, 32'h8C22_0004));
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    n_total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 ||
        mem_op !== 3'b000 || busy !== 1'b1)
      $display("FAIL if_acc1: en=%b we=%b addr=%h op=%b busy=%b want 1 0 10 000 1",
               mem_en, mem_we, mem_addr, mem_op, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h10 || if_ack !== 1'b0)
      $display("FAIL if_acc2: en=%b addr=%h ack=%b want 1 10 0", mem_en, mem_addr, if_ack);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL if_ack_cycle: if_ack=%b dm_ack=%b en=%b want 1 0 0", if_ack, dm_ack, mem_en);
    else n_pass++;
    n_total++;
    if (exp_q.size() == 0) $display("FAIL if_sb: got empty queue want entry");
    else begin
      ent = exp_q.pop_front();
      if (if_rdata !== ent.rdata || ent.is_dm !== 1'b0)
        $display("FAIL if_rdata: got %h want %h", if_rdata, ent.rdata);
      else n_pass++;
    end
    if_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (if_ack !== 1'b0 || busy !== 1'b0)
      $display("FAIL if_done: ack=%b busy=%b want 0 0", if_ack, busy);
    else n_pass++;
  endtask

  task automatic test_dm_store();
    exp_t ent;
    exp_q.push_back(mk(1'b1, 32'h0));
    dm_req = 1'b1; dm_wr = 1'b1; dm_op = 3'b010;
    dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF ||
        mem_addr !== 32'h100 || mem_op !== 3'b010)
      $display("FAIL st_acc1: en=%b we=%b wd=%h addr=%h op=%b want 1 1 deadbeef 100 010",
               mem_en, mem_we, mem_wdata, mem_addr, mem_op);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL st_acc2: we=%b wd=%h want 1 deadbeef", mem_we, mem_wdata);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (dm_ack !== 1'b1 || if_ack !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL st_ack: dm_ack=%b if_ack=%b we=%b want 1 0 0", dm_ack, if_ack, mem_we);
    else n_pass++;
    n_total++;
    if (exp_q.size() == 0) $display("FAIL st_sb: got empty queue want entry");
    else begin
      ent = exp_q.pop_front();
      if (dm_rdata !== ent.rdata)
        $display("FAIL st_rdata: got %h want %h", dm_rdata, ent.rdata);
      else n_pass++;
    end
    dm_req = 1'b0; dm_wr = 1'b0;
    @(negedge clk);
    n_total++;
    if (dm_ack !== 1'b0) $display("FAIL st_single_pulse: dm_ack=%b want 0", dm_ack);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    exp_t ent;
    int   got_ack;
    logic no_ack;
    dm_req = 1'b1; dm_wr = 1'b0; dm_op = 3'b100; dm_addr = 32'h0000_0200;
    @(negedge clk);
    n_total++;
    if (mem_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL rst_pre: en=%b busy=%b want 1 1", mem_en, busy);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({mem_en, mem_we, mem_op, mem_addr, mem_wdata, if_ack, dm_ack,
         if_rdata, dm_rdata, busy} !== '0)
      $display("FAIL rst_async: got %h want 0",
               {mem_en, mem_we, mem_op, mem_addr, mem_wdata, if_ack, dm_ack,
                if_rdata, dm_rdata, busy});
    else n_pass++;
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    no_ack = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (dm_ack !== 1'b0 || if_ack !== 1'b0 || busy !== 1'b0) no_ack = 1'b0;
    end
    n_total++;
    if (no_ack !== 1'b1) $display("FAIL rst_dropped: got activity=1 want 0");
    else n_pass++;
    exp_q.push_back(mk(1'b0, mem_word(32'h10)));
    if_req = 1'b1; if_addr = 32'h0000_0010;
    got_ack = 0;
    for (int c = 0; c < 10 && got_ack == 0; c++) begin
      @(negedge clk);
      if (if_ack === 1'b1 || dm_ack === 1'b1) begin
        got_ack = 1;
        if_req  = 1'b0;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL rst_fetch_sb: got empty queue want entry");
        else begin
          ent = exp_q.pop_front();
          if (if_ack !== 1'b1 || if_rdata !== ent.rdata || dm_rdata !== 32'h0)
            $display("FAIL rst_fetch: if_ack=%b rdata=%h dm_rdata=%h want 1 %h 0",
                     if_ack, if_rdata, dm_rdata, ent.rdata);
          else n_pass++;
        end
      end
    end
    if (got_ack == 0) begin
      n_total++;
      if_req = 1'b0;
      $display("FAIL rst_fetch_timeout: got no ack want ack");
    end
  endtask

  task automatic test_simultaneous();
    exp_t ent;
    int   acks = 0;
    int   ack_cyc[2] = '{0, 0};
    logic overlap = 1'b0;
    exp_q.push_back(mk(1'b1, 32'h1234_5678));
    exp_q.push_back(mk(1'b0, mem_word(32'h30)));
    dm_req = 1'b1; dm_wr = 1'b0; dm_op = 3'b010; dm_addr = 32'h0000_0200;
    if_req = 1'b1; if_addr = 32'h0000_0030;
    for (int c = 1; c <= 20 && acks < 2; c++) begin
      @(negedge clk);
      if (if_ack === 1'b1 && dm_ack === 1'b1) overlap = 1'b1;
      if (if_ack === 1'b1 || dm_ack === 1'b1) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL sim_sb: got empty queue want entry");
        else begin
          ent = exp_q.pop_front();
          if (dm_ack !== ent.is_dm || (dm_ack ? dm_rdata : if_rdata) !== ent.rdata)
            $display("FAIL sim_ack%0d: dm_ack=%b rdata=%h want %b %h", acks, dm_ack,
                     dm_ack ? dm_rdata : if_rdata, ent.is_dm, ent.rdata);
          else n_pass++;
        end
        if (dm_ack === 1'b1) dm_req = 1'b0;
        if (if_ack === 1'b1) if_req = 1'b0;
        ack_cyc[acks] = c;
        acks++;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    n_total++;
    if (acks != 2) $display("FAIL sim_timeout: got %0d acks want 2", acks);
    else n_pass++;
    n_total++;
    if (ack_cyc[1] - ack_cyc[0] != MEM_LAT + 2)
      $display("FAIL sim_spacing: got %0d want %0d", ack_cyc[1] - ack_cyc[0], MEM_LAT + 2);
    else n_pass++;
    n_total++;
    if (overlap !== 1'b0) $display("FAIL sim_overlap: got 1 want 0");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t ent;
    int   acks = 0;
    int   raise_at = -1;
    int   ack_cyc[5] = '{0, 0, 0, 0, 0};
    logic [4:0] kinds = 5'b0;
    logic spacing_ok = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, mem_word(32'h40)));
    if_req = 1'b1; if_addr = 32'h0000_0040;
    for (int c = 1; c <= 40 && acks < 5; c++) begin
      @(negedge clk);
      if (if_ack === 1'b1 || dm_ack === 1'b1) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_sb: got empty queue want entry");
        else begin
          ent = exp_q.pop_front();
          if (dm_ack !== ent.is_dm || if_ack === dm_ack ||
              (dm_ack ? dm_rdata : if_rdata) !== ent.rdata)
            $display("FAIL b2b_ack%0d: dm_ack=%b if_ack=%b rdata=%h want dm=%b %h", acks,
                     dm_ack, if_ack, dm_ack ? dm_rdata : if_rdata, ent.is_dm, ent.rdata);
          else n_pass++;
        end
        kinds[acks]   = dm_ack;
        ack_cyc[acks] = c;
        acks++;
        if (dm_ack === 1'b1) dm_req = 1'b0;
        if (if_ack === 1'b1 && acks == 5) if_req = 1'b0;
        if (acks == 2) raise_at = c + 2;
      end
      if (c == raise_at) begin
        exp_q.push_back(mk(1'b1, mem_word(32'h80)));
        exp_q.push_back(mk(1'b0, mem_word(32'h40)));
        dm_req = 1'b1; dm_wr = 1'b0; dm_op = 3'b000; dm_addr = 32'h0000_0080;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    for (int i = 1; i < 5; i++)
      if (ack_cyc[i] - ack_cyc[i-1] != MEM_LAT + 2) spacing_ok = 1'b0;
    n_total++;
    if (acks != 5 || kinds !== 5'b01000)
      $display("FAIL b2b_order: acks=%0d kinds=%b want 5 01000", acks, kinds);
    else n_pass++;
    n_total++;
    if (spacing_ok !== 1'b1) $display("FAIL b2b_spacing: got uneven want %0d", MEM_LAT + 2);
    else n_pass++;
  endtask

  task automatic test_both_held();
    exp_t ent;
    int   acks = 0;
    logic [3:0] kinds = 4'b0;
    logic [3:0] want;
`ifdef MEM_ARB_RR_EN
    want = 4'b0101;
`else
    want = 4'b1111;
`endif
    for (int i = 0; i < 4; i++)
      exp_q.push_back(want[i] ? mk(1'b1, mem_word(32'h300)) : mk(1'b0, mem_word(32'h50)));
    dm_req = 1'b1; dm_wr = 1'b0; dm_op = 3'b010; dm_addr = 32'h0000_0300;
    if_req = 1'b1; if_addr = 32'h0000_0050;
    for (int c = 1; c <= 40 && acks < 4; c++) begin
      @(negedge clk);
      if (if_ack === 1'b1 || dm_ack === 1'b1) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL both_sb: got empty queue want entry");
        else begin
          ent = exp_q.pop_front();
          if (dm_ack !== ent.is_dm || if_ack === dm_ack ||
              (dm_ack ? dm_rdata : if_rdata) !== ent.rdata)
            $display("FAIL both_ack%0d: dm_ack=%b rdata=%h want dm=%b %h", acks, dm_ack,
                     dm_ack ? dm_rdata : if_rdata, ent.is_dm, ent.rdata);
          else n_pass++;
        end
        kinds[acks] = dm_ack;
        acks++;
        if (acks == 4) begin
          dm_req = 1'b0; if_req = 1'b0;
        end
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    n_total++;
    if (acks != 4 || kinds !== want)
      $display("FAIL both_order: acks=%0d grants=%b want 4 %b", acks, kinds, want);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL sb_drained: left=%0d busy=%b want 0 0", exp_q.size(), busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_store();
    test_reset_mid_access();
    test_simultaneous();
    test_back_to_back();
    test_both_held();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
